// File: rtl/compound_fanout_pkg.sv
// Shared types for the compound fan-out block: payload type, FSM sections,
// distribution modes and parameter defaults.
package top_level_types;
  typedef struct packed {
    logic [7:0]  tag;
    logic [15:0] data;
  } CompoundType;
endpackage

package compound_fanout_types;
  typedef enum logic [1:0] {
    SEC_IDLE  = 2'd0,
    SEC_PUSH  = 2'd1,
    SEC_FLUSH = 2'd2
  } Sections;

  localparam int MODE_BCAST = 0;
  localparam int MODE_RR    = 1;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_MODE   = MODE_BCAST;

  // Pointer width that stays at least one bit for a single channel.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/compound_fanout_fifo.sv
// Per-channel FIFO with a combinational head view, masked to zero when empty
// so an empty channel never shows stale payload.
module compound_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  T              i_din,
  output T              o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full && !i_clr;
  assign w_do_pop  = i_pop && !o_empty && !i_clr;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/compound_fanout.sv
// Fans a captured sample out to NUM_CH blocking FIFO channels, either as a
// broadcast or round-robin, with a stall counter for blocked push cycles.
module compound_fanout
  import top_level_types::*;
  import compound_fanout_types::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int MODE   = DEF_MODE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  CompoundType              m_in,
  input  logic                     m_in_en,
  input  logic                     flush,
  output CompoundType [NUM_CH-1:0] b_out,
  output logic [NUM_CH-1:0]        b_out_notify,
  input  logic [NUM_CH-1:0]        b_out_sync,
  output Sections                  section_out,
  output logic [15:0]              stall_cnt
);
  localparam int PW = ptr_width(NUM_CH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              r_rst_q;
  Sections           r_section;
  CompoundType       r_hold;
  logic [PW-1:0]     r_rr_ptr;
  logic [15:0]       r_stall;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [CW-1:0]     w_count [NUM_CH];
  logic              w_can_push;
  logic              w_push_fire;
  logic              w_fifo_clr;

  // Reset asserts immediately but releases one clock later, so the first
  // state update lands on the second edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_q <= 1'b0;
    else      r_rst_q <= 1'b1;
  end

  always_comb begin
    w_can_push = 1'b0;
    if (MODE == MODE_RR) w_can_push = !w_full[r_rr_ptr];
    else                 w_can_push = ~|w_full;
  end

  assign w_push_fire = (r_section == SEC_PUSH) && !flush && w_can_push;
  assign w_fifo_clr  = flush || (r_section == SEC_FLUSH);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_push[gi]       = w_push_fire && ((MODE != MODE_RR) || (r_rr_ptr == PW'(gi)));
      assign w_pop[gi]        = b_out_sync[gi] && !w_empty[gi];
      assign b_out_notify[gi] = !w_empty[gi];

      compound_fifo #(
        .DEPTH (DEPTH),
        .T     (CompoundType)
      ) u_fifo (
        .clk     (clk),
        .i_rst_n (r_rst_q),
        .i_clr   (w_fifo_clr),
        .i_push  (w_push[gi]),
        .i_pop   (w_pop[gi]),
        .i_din   (r_hold),
        .o_dout  (b_out[gi]),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi]),
        .o_count (w_count[gi])
      );

      always_comb assert (w_count[gi] <= CW'(DEPTH));
    end
  endgenerate

  always_ff @(posedge clk or negedge r_rst_q) begin
    if (!r_rst_q) begin
      r_section <= SEC_IDLE;
      r_hold    <= '0;
      r_rr_ptr  <= '0;
      r_stall   <= '0;
    end else if (flush) begin
      r_section <= SEC_FLUSH;
      r_hold    <= '0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_section)
        SEC_IDLE: begin
          if (m_in_en) begin
            r_hold    <= m_in;
            r_section <= SEC_PUSH;
          end
        end
        SEC_PUSH: begin
          if (w_can_push) begin
            r_section <= SEC_IDLE;
            if (MODE == MODE_RR)
              r_rr_ptr <= (r_rr_ptr == PW'(NUM_CH - 1)) ? '0 : r_rr_ptr + PW'(1);
          end else if (r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
          end
        end
        SEC_FLUSH: begin
          r_section <= SEC_IDLE;
          r_hold    <= '0;
          r_rr_ptr  <= '0;
        end
        default: r_section <= SEC_IDLE;
      endcase
    end
  end

  assign section_out = r_section;
  assign stall_cnt   = r_stall;
endmodule

// File: tb/tb_compound_fanout.sv
// Bench: a broadcast instance (2 ch) and a round-robin instance (3 ch) checked
// every cycle against a queue-based model, plus hand-computed literal checks.
module tb_compound_fanout;
  import top_level_types::*;
  import compound_fanout_types::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en  [2];
  CompoundType min [2];
  logic        fl  [2];
  logic [2:0]  sy  [2];

  CompoundType [1:0] bo0;
  logic [1:0]        no0;
  Sections           sc0;
  logic [15:0]       st0;
  CompoundType [2:0] bo1;
  logic [2:0]        no1;
  Sections           sc1;
  logic [15:0]       st1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  compound_fanout #(.NUM_CH(2), .DEPTH(D), .MODE(MODE_BCAST)) u_bcast (
    .clk(clk), .rst(rst), .m_in(min[0]), .m_in_en(en[0]), .flush(fl[0]),
    .b_out(bo0), .b_out_notify(no0), .b_out_sync(sy[0][1:0]),
    .section_out(sc0), .stall_cnt(st0)
  );

  compound_fanout #(.NUM_CH(3), .DEPTH(D), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst(rst), .m_in(min[1]), .m_in_en(en[1]), .flush(fl[1]),
    .b_out(bo1), .b_out_notify(no1), .b_out_sync(sy[1]),
    .section_out(sc1), .stall_cnt(st1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic CompoundType mk(input logic [7:0] t, input logic [15:0] d);
    CompoundType v;
    v.tag  = t;
    v.data = d;
    return v;
  endfunction

  function automatic int nch(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int mmode(input int i);
    return (i == 0) ? MODE_BCAST : MODE_RR;
  endfunction

  // ---------------- behavioural model ----------------
  CompoundType mq [2][3][$];
  Sections     msec  [2];
  CompoundType mhold [2];
  int          mrr   [2];
  logic [15:0] mstall[2];
  bit          msync;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 3; c++) mq[i][c].delete();
      msec[i]   = SEC_IDLE;
      mhold[i]  = '0;
      mrr[i]    = 0;
      mstall[i] = '0;
    end
    msync = 1'b0;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int sz [3];
      int n;
      bit ok;
      n = nch(i);
      for (int c = 0; c < 3; c++) sz[c] = mq[i][c].size();
      if (fl[i]) begin
        for (int c = 0; c < 3; c++) mq[i][c].delete();
        msec[i]  = SEC_FLUSH;
        mrr[i]   = 0;
        mhold[i] = '0;
      end else begin
        for (int c = 0; c < n; c++)
          if (sy[i][c] && sz[c] > 0) void'(mq[i][c].pop_front());
        case (msec[i])
          SEC_IDLE: if (en[i]) begin
            mhold[i] = min[i];
            msec[i]  = SEC_PUSH;
          end
          SEC_PUSH: begin
            if (mmode(i) == MODE_BCAST) begin
              ok = 1'b1;
              for (int c = 0; c < n; c++) if (sz[c] >= D) ok = 1'b0;
            end else begin
              ok = (sz[mrr[i]] < D);
            end
            if (ok) begin
              if (mmode(i) == MODE_BCAST) begin
                for (int c = 0; c < n; c++) mq[i][c].push_back(mhold[i]);
              end else begin
                mq[i][mrr[i]].push_back(mhold[i]);
                mrr[i] = (mrr[i] + 1) % n;
              end
              msec[i] = SEC_IDLE;
            end else if (mstall[i] != 16'hFFFF) begin
              mstall[i] = mstall[i] + 16'd1;
            end
          end
          default: begin
            for (int c = 0; c < 3; c++) mq[i][c].delete();
            msec[i]  = SEC_IDLE;
            mrr[i]   = 0;
            mhold[i] = '0;
          end
        endcase
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst)        model_reset();
      else if (!msync) msync = 1'b1;
      else             model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [2:0]  dnot [2];
  CompoundType dbo  [2][3];
  Sections     dsec [2];
  logic [15:0] dst  [2];

  initial begin
    forever begin
      @(negedge clk);
      dnot[0] = {1'b0, no0};
      dnot[1] = no1;
      dbo[0][0] = bo0[0]; dbo[0][1] = bo0[1]; dbo[0][2] = '0;
      dbo[1][0] = bo1[0]; dbo[1][1] = bo1[1]; dbo[1][2] = bo1[2];
      dsec[0] = sc0; dsec[1] = sc1;
      dst[0]  = st0; dst[1]  = st1;
      for (int i = 0; i < 2; i++) begin
        logic [2:0] exp_n;
        exp_n = '0;
        for (int c = 0; c < nch(i); c++) begin
          exp_n[c] = (mq[i][c].size() > 0);
          check($sformatf("m%0d b_out[%0d]", i, c), 64'(dbo[i][c]),
                64'((mq[i][c].size() > 0) ? mq[i][c][0] : CompoundType'('0)));
        end
        check($sformatf("m%0d notify", i), 64'(dnot[i]), 64'(exp_n));
        check($sformatf("m%0d section", i), 64'(dsec[i]), 64'(msec[i]));
        check($sformatf("m%0d stall_cnt", i), 64'(dst[i]), 64'(mstall[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input CompoundType v);
    en[i]  = 1'b1;
    min[i] = v;
    tick();
    en[i] = 1'b0;
    tick();
    $display("txn inst=%0d tag=%h data=%h", i, v.tag, v.data);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; min[i] = '0; fl[i] = 1'b0; sy[i] = '0;
    end
    #3;
    check("reset notify0", 64'(no0), 64'(0));
    check("reset b_out0", 64'(bo0), 64'(0));
    check("reset section0", 64'(sc0), 64'(SEC_IDLE));
    check("reset stall0", 64'(st0), 64'(0));
    tick(); tick();

    // Broadcast, 2-cycle latency, release synchronised by one edge
    rst = 1'b1;
    en[0] = 1'b1; min[0] = mk(8'h0A, 16'hA001); sy[0] = 3'b011; sy[1] = 3'b111;
    tick();
    check("sync edge ignored", 64'(sc0), 64'(SEC_IDLE));
    tick();
    en[0] = 1'b0;
    check("captured to push", 64'(sc0), 64'(SEC_PUSH));
    tick();
    check("bcast notify", 64'(no0), 64'(2'b11));
    check("bcast ch0 A", 64'(bo0[0]), 64'(mk(8'h0A, 16'hA001)));
    check("bcast ch1 A", 64'(bo0[1]), 64'(mk(8'h0A, 16'hA001)));
    tick();
    check("bcast popped", 64'(no0), 64'(0));

    // Round robin over 3 channels
    send(1, mk(8'h0A, 16'h000A));
    check("rr A ch0", 64'(no1), 64'(3'b001));
    check("rr A data", 64'(bo1[0]), 64'(mk(8'h0A, 16'h000A)));
    send(1, mk(8'h0B, 16'h000B));
    check("rr B ch1", 64'(no1), 64'(3'b010));
    send(1, mk(8'h0C, 16'h000C));
    check("rr C ch2", 64'(no1), 64'(3'b100));
    send(1, mk(8'h0D, 16'h000D));
    check("rr D ch0", 64'(no1), 64'(3'b001));
    check("rr D data", 64'(bo1[0]), 64'(mk(8'h0D, 16'h000D)));
    send(1, mk(8'h0E, 16'h000E));
    check("rr ptr at 1", 64'(no1), 64'(3'b010));
    tick();

    // Channel 1 blocked: fill it, then stall on the 5th sample
    sy[0] = 3'b001;
    for (int k = 1; k <= 4; k++) send(0, mk(8'h50, 16'(k)));
    check("fill notify", 64'(no0), 64'(2'b11));
    check("fill ch1 head", 64'(bo0[1]), 64'(mk(8'h50, 16'd1)));
    en[0] = 1'b1; min[0] = mk(8'h50, 16'd5);
    tick();
    en[0] = 1'b0;
    tick(); tick(); tick();
    check("stall section", 64'(sc0), 64'(SEC_PUSH));
    check("stall count 3", 64'(st0), 64'(3));
    sy[0] = 3'b011;
    tick();
    check("full pop blocks push", 64'(st0), 64'(4));
    check("still pushing", 64'(sc0), 64'(SEC_PUSH));
    check("pop took head", 64'(bo0[1]), 64'(mk(8'h50, 16'd2)));
    tick();
    check("push landed", 64'(sc0), 64'(SEC_IDLE));
    check("stall held 4", 64'(st0), 64'(4));
    check("ch1 order", 64'(bo0[1]), 64'(mk(8'h50, 16'd3)));
    check("ch0 got 5th", 64'(bo0[0]), 64'(mk(8'h50, 16'd5)));
    tick(); tick(); tick();
    check("drained", 64'(no0), 64'(0));

    // Flush while pushing
    sy[0] = 3'b000;
    send(0, mk(8'hF1, 16'h0F01));
    check("pre-flush notify", 64'(no0), 64'(2'b11));
    en[0] = 1'b1; min[0] = mk(8'hF2, 16'h0F02);
    tick();
    check("pre-flush push", 64'(sc0), 64'(SEC_PUSH));
    fl[0] = 1'b1;
    tick();
    check("flush section", 64'(sc0), 64'(SEC_FLUSH));
    check("flush notify", 64'(no0), 64'(0));
    check("flush keeps stall", 64'(st0), 64'(4));
    fl[0] = 1'b0;
    tick();
    en[0] = 1'b0;
    check("flush to idle", 64'(sc0), 64'(SEC_IDLE));
    tick();
    check("hold discarded", 64'(no0), 64'(0));

    // Flush resets the round-robin pointer
    fl[1] = 1'b1;
    tick();
    fl[1] = 1'b0;
    tick();
    send(1, mk(8'h61, 16'h0061));
    check("rr restart ch0", 64'(no1), 64'(3'b001));
    check("rr restart data", 64'(bo1[0]), 64'(mk(8'h61, 16'h0061)));
    tick();

    // Asynchronous reset with half-full FIFOs
    send(0, mk(8'h71, 16'h0071));
    send(0, mk(8'h72, 16'h0072));
    check("half full", 64'(no0), 64'(2'b11));
    rst = 1'b0;
    #1;
    check("async notify drop", 64'(no0), 64'(0));
    check("async b_out zero", 64'(bo0), 64'(0));
    check("async stall zero", 64'(st0), 64'(0));
    check("async rr notify", 64'(no1), 64'(0));
    tick();
    rst = 1'b1;
    en[0] = 1'b1; min[0] = mk(8'h80, 16'h0080); sy[0] = 3'b011;
    tick();
    tick();
    en[0] = 1'b0;
    tick();
    check("post-reset notify", 64'(no0), 64'(2'b11));
    check("post-reset data", 64'(bo0[0]), 64'(mk(8'h80, 16'h0080)));
    tick();
    check("post-reset pop", 64'(no0), 64'(0));
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/compound_fanout.md
COMPOUND_FANOUT -- requirements
Module: compound_fanout

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 2, meaning the number of blocking output channels (legal range 1..8).
REQ-002 The block SHALL take parameter DEPTH, default 4, meaning the per-channel FIFO depth (power of two, legal range 2..16).
REQ-003 The block SHALL take parameter MODE, default MODE_BCAST, meaning the distribution mode: MODE_BCAST copies each sample to every channel; MODE_RR sends each sample to one channel, round-robin.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 m_in  input  CompoundType  master-in sample source, valid whenever m_in_en=1.
REQ-007 m_in_en  input  1  request to capture m_in.
REQ-008 flush  input  1  synchronous clear of all FIFOs.
REQ-009 b_out  output  CompoundType[NUM_CH]  head entry of each channel FIFO.
REQ-010 b_out_notify  output  [NUM_CH]  channel i holds valid data.
REQ-011 b_out_sync  input  [NUM_CH]  consumer i accepts this cycle.
REQ-012 section_out  output  Sections  current FSM section.
REQ-013 stall_cnt  output  16  saturating count of blocked push cycles.

Function
REQ-014 The FSM SHALL have the sections SEC_IDLE, SEC_PUSH and SEC_FLUSH.
REQ-015 SEC_IDLE with m_in_en=1: latch m_in into the hold register; next section is SEC_PUSH. With m_in_en=0: stay in SEC_IDLE.
REQ-016 SEC_PUSH in MODE_BCAST: if every FIFO is non-full, write the hold register to all FIFOs in the same cycle and go to SEC_IDLE; otherwise stay in SEC_PUSH and write nothing.
REQ-017 SEC_PUSH in MODE_RR: if FIFO[rr_ptr] is non-full, write to it, advance rr_ptr (NUM_CH-1 wraps to 0) and go to SEC_IDLE; otherwise stay in SEC_PUSH.
REQ-018 Each cycle spent in SEC_PUSH without a write SHALL increment stall_cnt, saturating at 16'hFFFF.
REQ-019 Full/space decisions SHALL use the registered FIFO count; a pop in the same cycle does not free space for that cycle's push.
REQ-020 b_out_notify[i] SHALL equal !empty[i], and b_out[i] SHALL equal the head of FIFO i.
REQ-021 A transfer on channel i SHALL occur iff b_out_notify[i] && b_out_sync[i]; the transfer pops FIFO i.
REQ-022 b_out_sync while empty SHALL be ignored.
REQ-023 There SHALL be no bypass: a write into an empty FIFO raises notify on the following cycle.
REQ-024 Latency SHALL be 2 cycles: m_in_en sampled at edge k (in SEC_IDLE) with space available gives b_out_notify high after edge k+1.
REQ-025 Simultaneous push and pop on the same FIFO SHALL leave the count unchanged and preserve order.
REQ-026 flush=1 in any section SHALL move the FSM to SEC_FLUSH; in SEC_FLUSH all FIFOs empty, rr_ptr is set to 0 and the hold data is discarded.
REQ-027 SEC_FLUSH SHALL last one cycle and then go to SEC_IDLE; stall_cnt is not cleared by flush.
REQ-028 flush SHALL take priority over push, pop and m_in_en in the same cycle.

Reset
REQ-029 While rst=0, regardless of clk: section SEC_IDLE, all FIFOs empty, b_out_notify all 0, b_out all 0, rr_ptr 0, stall_cnt 0, hold register 0.
REQ-030 Reset asserted in the middle of SEC_PUSH SHALL discard the pending sample; no partial broadcast remains.
REQ-031 Reset deassertion SHALL be synchronised internally; the first state update occurs on the second clk edge after rst rises.

Structure
REQ-032 Package compound_fanout_types SHALL hold the Sections enum, the MODE_BCAST/MODE_RR constants and the parameter defaults; CompoundType stays in top_level_types.
REQ-033 One sub-module, compound_fifo (parametrised by DEPTH, CompoundType payload, push/pop/full/empty/count), SHALL be instantiated NUM_CH times.
REQ-034 The FSM, round-robin pointer and stall counter SHALL live in compound_fanout.

Verification
REQ-035 BCAST, NUM_CH=2: m_in=A with en for 1 cycle, both syncs=1 -> both notify high 2 cycles later, both b_out=A, popped next edge.
REQ-036 RR, NUM_CH=3: samples A,B,C,D, all syncs=1 -> channel 0 gets A then D, channel 1 gets B, channel 2 gets C; rr_ptr=1 at end.
REQ-037 BCAST, DEPTH=4: sync[1]=0, 5 samples -> FSM holds SEC_PUSH on the 5th sample and stall_cnt increments; raising sync[1] completes the push.
REQ-038 Channel full with push and pop in the same cycle -> push blocked that cycle (stall_cnt+1), pop succeeds, push lands on the next cycle.
REQ-039 flush together with m_in_en in SEC_PUSH -> SEC_FLUSH, all notify 0 next cycle, then SEC_IDLE; stall_cnt is retained.
REQ-040 rst=0 pulse while FIFOs are half full -> notify drops asynchronously to 0; after release the first new sample appears with 2-cycle latency.
